psr_unit: RTL and testbench
===========================

# psr_unit

Processor status register for the function unit, and the consumer of the ALU's `ALU_Result`/`C`/`V`/`PSR_Write` outputs.
- Latches the N, Z, C and V flags whenever the ALU requests a PSR write.
- Holds a small save/restore stack for interrupt entry and return.
- Evaluates a 4-bit condition code against the current flags for branch and predication logic.
- Sits between the ALU and the sequencer.

## Interface
Parameters:
- `WORD_SIZE`, 32, width of the ALU result.
- `STACK_DEPTH`, 4, number of saved PSR entries (≥2).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_result`  in  WORD_SIZE  ALU result for the current op.
- `alu_c`  in  1  ALU carry-out.
- `alu_v`  in  1  ALU overflow.
- `psr_write`  in  1  ALU flag-update request (the ALU's `PSR_Write`).
- `psr_load`  in  1  software write of the flags.
- `psr_load_data`  in  4  {N,Z,C,V} for `psr_load`.
- `push`  in  1  save the current flags onto the stack.
- `pop`  in  1  restore the flags from the top of the stack.
- `cond`  in  4  condition code select.
- `cond_true`  out  1  `cond` evaluated against the registered flags.
- `flags`  out  4  registered {N,Z,C,V}.
- `depth`  out  clog2(STACK_DEPTH+1)  current number of stack entries.
- `stack_full`  out  1  `depth == STACK_DEPTH`.
- `stack_empty`  out  1  `depth == 0`.
- `err_overflow`  out  1  sticky: push attempted while full.
- `err_underflow`  out  1  sticky: pop attempted while empty.
- `err_clear`  in  1  clears both sticky errors.

## Operation
- ALU update when `psr_write` is high:
  - N = `alu_result[WORD_SIZE-1]`.
  - Z = (`alu_result` == 0).
  - C = `alu_c`, V = `alu_v`.
  - Inputs are sampled at the edge; the ALU is combinational, so its outputs must be stable by then.
- Flag-source priority, highest first: valid pop, `psr_load`, `psr_write`, hold.
- Stack behaviour:
  - Push writes the pre-edge `flags` at index `depth` and increments `depth`.
  - Pop loads `flags` from entry `depth-1` and decrements `depth`.
- `push` and `pop` in the same cycle, stack neither empty nor full: stack and `depth` unchanged. `flags` takes the top entry (equivalent to a pop followed by re-pushing the old flags into the vacated slot). This is defined as a swap.
- `push` and `pop` together with stack empty: treat as push only, no underflow error.
- `push` and `pop` together with stack full: treat as swap, no overflow error.
- Push while full, alone: ignored; `err_overflow` set; a concurrent `psr_write`/`psr_load` still applies.
- Pop while empty, alone: ignored; `err_underflow` set; lower-priority flag sources then apply.
- Push together with `psr_write` or `psr_load`: the pushed value is the old flags, and `flags` takes the new value.
- `err_clear` together with a new error event: set wins.
- Condition codes (`cond`):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- `cond_true` is combinational from registered `flags` and `cond` only; there is no path from `alu_*` inputs.

## Timing
- Reset values:
  - `flags` = 4'b0000, `depth` = 0, stack entries = 0.
  - `stack_empty` = 1, `stack_full` = 0.
  - `err_overflow` = `err_underflow` = 0.
  - `cond_true` = 1 for AL; otherwise it follows the zero flags (e.g. NE=1, EQ=0).
- Reset asserted mid-operation clears everything immediately, with no clock needed. Release is synchronous to `clk` by the surrounding reset synchroniser.
- Update latency: a flag update or push/pop requested at edge k is visible on `flags`, `depth`, `cond_true`, full/empty and the errors after edge k.
- `stack_full` and `stack_empty` are decoded from registered `depth`.
- There are no handshakes; every request is accepted or errored in a single cycle.

## Structure
- Package `psr_pkg` holds:
  - condition-code localparams `COND_EQ` … `COND_NV`;
  - flag bit indices `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`;
  - the flags vector width (4).
- Sub-module `psr_cond_eval`: purely combinational `cond` × `flags` → `cond_true`, reused by the sequencer's branch unit.
- The stack is a register array indexed by `depth`; no RAM macro.

## Test plan
- Reset: set `flags`=1111 with `depth`=2, then pulse `reset_n` low without a clock → `flags`=0000, `depth`=0, `stack_empty`=1, errors 0.
- ALU update and conditions:
  - `psr_write` with `alu_result`=0x8000_0000, `alu_c`=1, `alu_v`=1 → next cycle `flags`=1011; GE=1, LT=0, HI=1.
  - Then `alu_result`=0 with C=0, V=0 → `flags`=0100; EQ=1, LS=1.
- Fill and overflow: push 5 times with `flags` set to 0001, 0010, 0011, 0100, 0101 before each push → `depth`=4, `stack_full`=1, 5th push sets `err_overflow`. Popping 4× returns 0100, 0011, 0010, 0001 in order.
- Underflow: pop with `depth`=0 and `psr_write` high, `alu_result`=1 → `err_underflow`=1, `flags`=0000 from the ALU, `depth`=0. `err_clear` alone → error clears; `err_clear` with another underflow → stays 1.
- Simultaneous events:
  - Push with `psr_load` 1111 while `flags`=0010 → top entry=0010, `flags`=1111.
  - Push+pop at `depth`=2, top entry=0110, `flags`=1001 → `flags`=0110, top entry=1001, `depth`=2.
- Exhaustive `cond`: all 16 codes × all 16 flag values checked against a reference model in `psr_cond_eval`.

Source files
------------

// File: rtl/psr_pkg.sv
// Shared flag layout and condition-code encodings for the processor status register.
package psr_pkg;

   localparam int unsigned FLAG_W = 4;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/psr_cond_eval.sv
// Combinational condition-code evaluator; also reused by the branch unit.
module psr_cond_eval
   import psr_pkg::*;
(
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] flags,
   output logic              cond_true
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = ~v;
         COND_HI: cond_true = c & ~z;
         COND_LS: cond_true = ~c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = ~z & (n == v);
         COND_LE: cond_true = z | (n != v);
         COND_AL: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/psr_unit.sv
// Processor status register: ALU flag capture, software load, save/restore stack, condition evaluation.
module psr_unit
   import psr_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 32,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [WORD_SIZE-1:0]                 alu_result,
   input  logic                                 alu_c,
   input  logic                                 alu_v,
   input  logic                                 psr_write,
   input  logic                                 psr_load,
   input  logic [FLAG_W-1:0]                    psr_load_data,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic [3:0]                           cond,
   output logic                                 cond_true,
   output logic [FLAG_W-1:0]                    flags,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
   output logic                                 stack_full,
   output logic                                 stack_empty,
   output logic                                 err_overflow,
   output logic                                 err_underflow,
   input  logic                                 err_clear
);

   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W   = $clog2(STACK_DEPTH);

   flags_t               flags_q, flags_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   flags_t               stack_q [STACK_DEPTH];

   logic                 wr_en;
   logic [IDX_W-1:0]     wr_idx;
   logic [IDX_W-1:0]     top_idx;
   logic [IDX_W-1:0]     push_idx;
   flags_t               alu_flags;

   assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign stack_empty = (depth_q == '0);
   assign top_idx     = IDX_W'(depth_q - DEPTH_W'(1));
   assign push_idx    = IDX_W'(depth_q);

   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_N] = alu_result[WORD_SIZE-1];
      alu_flags[FLAG_Z] = (alu_result == '0);
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
   end

   // Next-state: a valid pop (or swap) overrides load, which overrides the ALU write.
   always_comb begin
      flags_d = flags_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = push_idx;

      if (err_clear) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (psr_load)
         flags_d = psr_load_data;
      else if (psr_write)
         flags_d = alu_flags;

      if (push && pop && !stack_empty) begin
         flags_d = stack_q[top_idx];
         wr_en   = 1'b1;
         wr_idx  = top_idx;
      end else if (push) begin
         if (stack_full) begin
            ovf_d = 1'b1;
         end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
         end
      end else if (pop) begin
         if (stack_empty) begin
            unf_d = 1'b1;
         end else begin
            flags_d = stack_q[top_idx];
            depth_d = depth_q - DEPTH_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < int'(STACK_DEPTH); i++)
            stack_q[i] <= '0;
      end else begin
         flags_q <= flags_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (wr_en)
            stack_q[wr_idx] <= flags_q;
      end
   end

   assign flags         = flags_q;
   assign depth         = depth_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

   psr_cond_eval u_cond_eval (
      .cond      (cond),
      .flags     (flags_q),
      .cond_true (cond_true)
   );

endmodule

// File: tb/tb_psr_unit.sv
// Directed, table-driven bench for psr_unit.
module tb_psr_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] alu_result;
   logic        alu_c, alu_v;
   logic        psr_write, psr_load;
   logic [3:0]  psr_load_data;
   logic        push, pop;
   logic [3:0]  cond;
   logic        cond_true;
   logic [3:0]  flags;
   logic [2:0]  depth;
   logic        stack_full, stack_empty;
   logic        err_overflow, err_underflow;
   logic        err_clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psr_unit #(.WORD_SIZE(32), .STACK_DEPTH(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .alu_result    (alu_result),
      .alu_c         (alu_c),
      .alu_v         (alu_v),
      .psr_write     (psr_write),
      .psr_load      (psr_load),
      .psr_load_data (psr_load_data),
      .push          (push),
      .pop           (pop),
      .cond          (cond),
      .cond_true     (cond_true),
      .flags         (flags),
      .depth         (depth),
      .stack_full    (stack_full),
      .stack_empty   (stack_empty),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .err_clear     (err_clear)
   );

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic [3:0]  exp_flags;
   } alu_vec_t;

   typedef struct {
      logic [3:0] f;
      logic [3:0] cc;
      logic       exp;
   } cond_vec_t;

   alu_vec_t  alu_tab [5];
   cond_vec_t cond_tab [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge, sample just after it, then drop all strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      psr_write = 1'b0;
      psr_load  = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      err_clear = 1'b0;
   endtask

   task automatic load(input logic [3:0] d);
      psr_load      = 1'b1;
      psr_load_data = d;
      tick();
   endtask

   // Reference in condition-pair form: base predicate for cc[3:1], inverted by cc[0].
   function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cc[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c && !z;
         3'd5:    base = !(n ^ v);
         3'd6:    base = !z && !(n ^ v);
         default: base = 1'b1;
      endcase
      return cc[0] ? !base : base;
   endfunction

   initial begin
      alu_tab[0] = '{32'h8000_0000, 1'b1, 1'b1, 4'b1011};
      alu_tab[1] = '{32'h0000_0000, 1'b0, 1'b0, 4'b0100};
      alu_tab[2] = '{32'h0000_0001, 1'b0, 1'b0, 4'b0000};
      alu_tab[3] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1010};
      alu_tab[4] = '{32'h7FFF_FFFF, 1'b0, 1'b1, 4'b0001};

      cond_tab[0] = '{4'b1011, 4'hA, 1'b1};
      cond_tab[1] = '{4'b1011, 4'hB, 1'b0};
      cond_tab[2] = '{4'b1011, 4'h8, 1'b1};
      cond_tab[3] = '{4'b0100, 4'h0, 1'b1};
      cond_tab[4] = '{4'b0100, 4'h9, 1'b1};
      cond_tab[5] = '{4'b0000, 4'h1, 1'b1};
      cond_tab[6] = '{4'b0110, 4'hC, 1'b0};
      cond_tab[7] = '{4'b1000, 4'hD, 1'b1};
      cond_tab[8] = '{4'b1001, 4'hC, 1'b1};
      cond_tab[9] = '{4'b0000, 4'hF, 1'b0};

      reset_n = 1'b0;
      alu_result = '0; alu_c = 1'b0; alu_v = 1'b0;
      psr_write = 1'b0; psr_load = 1'b0; psr_load_data = '0;
      push = 1'b0; pop = 1'b0; err_clear = 1'b0;
      cond = 4'hE;

      // Reset state
      #3;
      check("rst_flags", 32'(flags), 32'h0);
      check("rst_depth", 32'(depth), 32'h0);
      check("rst_empty", 32'(stack_empty), 32'h1);
      check("rst_full", 32'(stack_full), 32'h0);
      check("rst_ovf", 32'(err_overflow), 32'h0);
      check("rst_unf", 32'(err_underflow), 32'h0);
      check("rst_al", 32'(cond_true), 32'h1);
      cond = 4'h1; #1;
      check("rst_ne", 32'(cond_true), 32'h1);
      cond = 4'h0; #1;
      check("rst_eq", 32'(cond_true), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset mid-operation
      load(4'b1111);
      push = 1'b1; tick();
      push = 1'b1; tick();
      check("pre_rst_depth", 32'(depth), 32'h2);
      check("pre_rst_flags", 32'(flags), 32'hF);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_flags", 32'(flags), 32'h0);
      check("async_rst_depth", 32'(depth), 32'h0);
      check("async_rst_empty", 32'(stack_empty), 32'h1);
      check("async_rst_ovf", 32'(err_overflow), 32'h0);
      check("async_rst_unf", 32'(err_underflow), 32'h0);
      #1 reset_n = 1'b1;

      // ALU update table
      for (int i = 0; i < 5; i++) begin
         alu_result = alu_tab[i].res;
         alu_c      = alu_tab[i].c;
         alu_v      = alu_tab[i].v;
         psr_write  = 1'b1;
         tick();
         check($sformatf("alu_flags[%0d]", i), 32'(flags), 32'(alu_tab[i].exp_flags));
      end

      // Hand-computed condition table
      for (int i = 0; i < 10; i++) begin
         load(cond_tab[i].f);
         cond = cond_tab[i].cc;
         #1;
         check($sformatf("cond_tab[%0d]", i), 32'(cond_true), 32'(cond_tab[i].exp));
      end

      // Fill and overflow
      for (int i = 1; i <= 5; i++) begin
         load(4'(i));
         push = 1'b1;
         tick();
      end
      check("fill_depth", 32'(depth), 32'h4);
      check("fill_full", 32'(stack_full), 32'h1);
      check("fill_ovf", 32'(err_overflow), 32'h1);
      check("fill_flags", 32'(flags), 32'h5);
      for (int i = 4; i >= 1; i--) begin
         pop = 1'b1;
         tick();
         check($sformatf("pop_flags[%0d]", i), 32'(flags), 32'(i));
         check($sformatf("pop_depth[%0d]", i), 32'(depth), 32'(i - 1));
      end
      check("drain_empty", 32'(stack_empty), 32'h1);

      // Underflow with concurrent ALU write
      pop = 1'b1; psr_write = 1'b1;
      alu_result = 32'h1; alu_c = 1'b0; alu_v = 1'b0;
      tick();
      check("unf_set", 32'(err_underflow), 32'h1);
      check("unf_flags", 32'(flags), 32'h0);
      check("unf_depth", 32'(depth), 32'h0);
      err_clear = 1'b1; tick();
      check("clr_unf", 32'(err_underflow), 32'h0);
      check("clr_ovf", 32'(err_overflow), 32'h0);
      err_clear = 1'b1; pop = 1'b1; tick();
      check("clr_vs_set", 32'(err_underflow), 32'h1);
      err_clear = 1'b1; tick();

      // Push with concurrent load
      load(4'b0010);
      push = 1'b1; psr_load = 1'b1; psr_load_data = 4'b1111;
      tick();
      check("pushld_flags", 32'(flags), 32'hF);
      check("pushld_depth", 32'(depth), 32'h1);
      pop = 1'b1; tick();
      check("pushld_top", 32'(flags), 32'h2);

      // Swap at depth 2
      load(4'b0011); push = 1'b1; tick();
      load(4'b0110); push = 1'b1; tick();
      load(4'b1001);
      push = 1'b1; pop = 1'b1; tick();
      check("swap_flags", 32'(flags), 32'h6);
      check("swap_depth", 32'(depth), 32'h2);
      pop = 1'b1; tick();
      check("swap_top", 32'(flags), 32'h9);
      pop = 1'b1; tick();
      check("swap_bottom", 32'(flags), 32'h3);

      // Push+pop on empty stack acts as push only
      push = 1'b1; pop = 1'b1; psr_load = 1'b1; psr_load_data = 4'b1100;
      tick();
      check("pp_empty_depth", 32'(depth), 32'h1);
      check("pp_empty_flags", 32'(flags), 32'hC);
      check("pp_empty_unf", 32'(err_underflow), 32'h0);
      pop = 1'b1; tick();
      check("pp_empty_top", 32'(flags), 32'h3);

      // Swap while full: no overflow
      for (int i = 0; i < 4; i++) begin
         load(4'(i + 8));
         push = 1'b1;
         tick();
      end
      load(4'b0111);
      push = 1'b1; pop = 1'b1; tick();
      check("swap_full_flags", 32'(flags), 32'hB);
      check("swap_full_depth", 32'(depth), 32'h4);
      check("swap_full_ovf", 32'(err_overflow), 32'h0);
      pop = 1'b1; tick();
      check("swap_full_top", 32'(flags), 32'h7);

      // Exhaustive condition codes against the reference
      for (int f = 0; f < 16; f++) begin
         load(4'(f));
         for (int c = 0; c < 16; c++) begin
            cond = 4'(c);
            #1;
            check($sformatf("cond f=%0h c=%0h", f, c), 32'(cond_true), 32'(ref_cond(4'(c), 4'(f))));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
